irq_prio_ctrl: RTL

- Interrupt front-end that feeds the 8-to-3 priority encoder stage.
- Synchronises 8 asynchronous request lines and latches their rising edges into a pending register.
- Applies a mask and selects the highest-numbered unmasked pending line through an internal encoder.
- Presents the winning index to a consumer with a valid/ack handshake, then clears the serviced pending bit.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/prio_enc8.sv | 23 ++
 rtl/irq_prio_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants, state encoding and index helpers for the interrupt front-end.
package irq_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        GAP
    } state_t;

    // One-hot vector with only the bit at position idx set.
    function automatic logic [N_REQ-1:0] idx_onehot(input idx_t idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder: highest-numbered set bit wins.
// sel is 0 and any is 0 when no input bit is set.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] eligible,
    output logic [IDX_W-1:0] sel,
    output logic             any
);

    // Ascending scan, so the last (highest) set bit overrides lower ones.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (eligible[i]) begin
                sel = idx_t'(i);
            end
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt front-end: synchronises 8 request lines, latches rising edges
// into a pending register, masks, picks the highest unmasked line and
// presents it over a valid/ack handshake (IDLE -> SERVE -> GAP).
// Optional ack timeout with irq_timeout pulse: define IRQ_TIMEOUT_EN.
module irq_prio_ctrl
    import irq_pkg::*;
`ifdef IRQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pending,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    input  logic             irq_ack
`ifdef IRQ_TIMEOUT_EN
    ,
    output logic             irq_timeout
`endif
);

    logic [N_REQ-1:0] r_s1;
    logic [N_REQ-1:0] r_s2;
    logic [N_REQ-1:0] r_s3;
    logic [N_REQ-1:0] r_pending;
    state_t           r_state;
    logic             r_valid;
    idx_t             r_idx;

    logic [N_REQ-1:0] w_rise;
    logic [N_REQ-1:0] w_eligible;
    idx_t             w_sel;
    logic             w_any;
    logic             w_accept;
    logic             w_expire;
    logic             w_drop;
    logic [N_REQ-1:0] w_clr;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= req_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise     = r_s2 & ~r_s3;
    assign w_eligible = r_pending & ~mask;

    prio_enc8 u_enc (
        .eligible (w_eligible),
        .sel      (w_sel),
        .any      (w_any)
    );

    // An ack only counts while an index is actually being presented.
    assign w_accept = (r_state == SERVE) && irq_ack;

`ifdef IRQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Ack wins over a coincident timeout, so expiry requires no ack.
    assign w_expire = (r_state == SERVE) && !irq_ack &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Ack timer: cleared on SERVE entry, counts every SERVE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (r_state != SERVE) begin
                r_cnt <= '0;
            end else if (!w_accept && !w_expire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign irq_timeout = r_timeout;
`else
    assign w_expire = 1'b0;
`endif

    // The serviced bit is released on ack, or dropped on timeout.
    assign w_drop = w_accept | w_expire;
    assign w_clr  = w_drop ? idx_onehot(r_idx) : '0;

    // Pending latch: a new rise in the same cycle as the clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_rise | (r_pending & ~w_clr);
        end
    end

    // Handshake FSM with registered valid/index; no preemption while serving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= SERVE;
                    end
                end
                SERVE: begin
                    if (w_drop) begin
                        r_valid <= 1'b0;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pending   = r_pending;
    assign irq_valid = r_valid;
    assign irq_idx   = r_idx;

endmodule
